// File: rtl/vec_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// vec_unit_arbiter_if
//   Bundles the requester-side handshake/result bus and the shared vector unit
//   operand/result bus of vec_unit_arbiter.
//
//   Requester side : i_req_valid, i_req_x/y/z (packed, requester k at
//                    [27k+26:27k]), o_req_ready (one-hot grant),
//                    o_res_valid (one-hot), o_res_x/y/z, o_res_tag
//   Unit side      : o_unit_x/y/z, o_unit_valid, i_unit_x/y/z
//
//   modport slave  : the arbiter
//   modport master : the environment (march cores + vector unit)
// ---------------------------------------------------------------------------
interface vec_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ*27-1:0] i_req_x;
    logic [NUM_REQ*27-1:0] i_req_y;
    logic [NUM_REQ*27-1:0] i_req_z;
    logic [NUM_REQ-1:0]    o_req_ready;

    logic [26:0]           o_unit_x;
    logic [26:0]           o_unit_y;
    logic [26:0]           o_unit_z;
    logic                  o_unit_valid;
    logic [26:0]           i_unit_x;
    logic [26:0]           i_unit_y;
    logic [26:0]           i_unit_z;

    logic [NUM_REQ-1:0]    o_res_valid;
    logic [26:0]           o_res_x;
    logic [26:0]           o_res_y;
    logic [26:0]           o_res_z;
    logic [TAG_W-1:0]      o_res_tag;

    modport slave (
        input  i_req_valid, i_req_x, i_req_y, i_req_z,
        input  i_unit_x, i_unit_y, i_unit_z,
        output o_req_ready,
        output o_unit_x, o_unit_y, o_unit_z, o_unit_valid,
        output o_res_valid, o_res_x, o_res_y, o_res_z, o_res_tag
    );

    modport master (
        output i_req_valid, i_req_x, i_req_y, i_req_z,
        output i_unit_x, i_unit_y, i_unit_z,
        input  o_req_ready,
        input  o_unit_x, o_unit_y, o_unit_z, o_unit_valid,
        input  o_res_valid, o_res_x, o_res_y, o_res_z, o_res_tag
    );
endinterface

// File: rtl/vec_unit_arbiter.sv
// ---------------------------------------------------------------------------
// vec_unit_arbiter
//   Round-robin sharing of one fixed-latency, fully pipelined vector unit
//   among NUM_REQ requesters. One grant per cycle at most; the granted
//   requester's x/y/z operands are registered onto the unit inputs and its
//   index travels down a tag/valid shift register matched to the unit
//   latency, so the result can be steered back to its owner.
//
//   Ports
//     i_clk     : clock
//     i_rst_n   : synchronous active-low reset
//     i_enable  : grant enable (0 stops new grants, in-flight ops drain)
//     bus       : vec_unit_arbiter_if.slave (requester + unit buses)
//     o_busy    : any op in flight
//
//   Optional build macro VEC_UNIT_ARB_PERF_EN adds saturating 32-bit
//   counters o_perf_issue_cnt, o_perf_conflict_cnt, o_perf_busy_cnt.
//   Functional behaviour is identical with or without it.
// ---------------------------------------------------------------------------
module vec_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 9,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    vec_unit_arbiter_if.slave bus,
    output logic              o_busy
`ifdef VEC_UNIT_ARB_PERF_EN
    ,
    output logic [31:0]       o_perf_issue_cnt,
    output logic [31:0]       o_perf_conflict_cnt,
    output logic [31:0]       o_perf_busy_cnt
`endif
);

    localparam int               OPW      = 27;
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);
    localparam logic [TAG_W:0]   NUM_EXT  = (TAG_W + 1)'(NUM_REQ);

    // ------------------------------------------------------------------
    // Round-robin grant (combinational, independent of anything downstream)
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               grant_any;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W:0]     scan_sum;
    logic [TAG_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] req_ready;

    // Scan from the pointer with an explicit modulo so that non power-of-two
    // NUM_REQ never produces an index >= NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (i_enable) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scan_sum = {1'b0, rr_ptr_q} + (TAG_W + 1)'(i);
                if (scan_sum >= NUM_EXT) begin
                    scan_sum = scan_sum - NUM_EXT;
                end
                scan_idx = scan_sum[TAG_W-1:0];
                if (!grant_any && bus.i_req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // A grant is always to a valid requester, so grant_any is the transfer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + TAG_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Issue registers
    // ------------------------------------------------------------------
    logic [OPW-1:0] unit_x_q, unit_x_d;
    logic [OPW-1:0] unit_y_q, unit_y_d;
    logic [OPW-1:0] unit_z_q, unit_z_d;
    logic           unit_valid_q, unit_valid_d;

    always_comb begin
        unit_x_d     = unit_x_q;
        unit_y_d     = unit_y_q;
        unit_z_d     = unit_z_q;
        unit_valid_d = grant_any;
        if (grant_any) begin
            unit_x_d = bus.i_req_x[int'(grant_idx)*OPW +: OPW];
            unit_y_d = bus.i_req_y[int'(grant_idx)*OPW +: OPW];
            unit_z_d = bus.i_req_z[int'(grant_idx)*OPW +: OPW];
        end
    end

    // ------------------------------------------------------------------
    // Tag/valid tracking. Stage 0 is loaded on the handshake edge; stage
    // LATENCY lines up with the cycle in which i_unit_* carries the result.
    // ------------------------------------------------------------------
    logic [LATENCY:0] sr_vld_q, sr_vld_d;
    logic [TAG_W-1:0] sr_tag_q [LATENCY+1];
    logic [TAG_W-1:0] sr_tag_d [LATENCY+1];

    always_comb begin
        sr_vld_d    = {sr_vld_q[LATENCY-1:0], grant_any};
        sr_tag_d[0] = grant_idx;
        for (int s = 1; s <= LATENCY; s++) begin
            sr_tag_d[s] = sr_tag_q[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Result return
    // ------------------------------------------------------------------
    logic [OPW-1:0]     res_x_q, res_x_d;
    logic [OPW-1:0]     res_y_q, res_y_d;
    logic [OPW-1:0]     res_z_q, res_z_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;

    // Data and tag hold when nothing returns; only the strobe drops.
    always_comb begin
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_z_d     = res_z_q;
        res_tag_d   = res_tag_q;
        res_valid_d = '0;
        if (sr_vld_q[LATENCY]) begin
            res_x_d                        = bus.i_unit_x;
            res_y_d                        = bus.i_unit_y;
            res_z_d                        = bus.i_unit_z;
            res_tag_d                      = sr_tag_q[LATENCY];
            res_valid_d[sr_tag_q[LATENCY]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_q     <= '0;
            unit_x_q     <= '0;
            unit_y_q     <= '0;
            unit_z_q     <= '0;
            unit_valid_q <= 1'b0;
            sr_vld_q     <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                sr_tag_q[s] <= '0;
            end
            res_x_q      <= '0;
            res_y_q      <= '0;
            res_z_q      <= '0;
            res_tag_q    <= '0;
            res_valid_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            unit_x_q     <= unit_x_d;
            unit_y_q     <= unit_y_d;
            unit_z_q     <= unit_z_d;
            unit_valid_q <= unit_valid_d;
            sr_vld_q     <= sr_vld_d;
            for (int s = 0; s <= LATENCY; s++) begin
                sr_tag_q[s] <= sr_tag_d[s];
            end
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
            res_z_q      <= res_z_d;
            res_tag_q    <= res_tag_d;
            res_valid_q  <= res_valid_d;
        end
    end

    logic busy;
    assign busy = (|sr_vld_q) | unit_valid_q;

`ifdef VEC_UNIT_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_busy_q, perf_busy_d;
    logic        multi_req;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_req = |(bus.i_req_valid & (bus.i_req_valid - NUM_REQ'(1)));

    always_comb begin
        perf_issue_d    = perf_issue_q;
        perf_conflict_d = perf_conflict_q;
        perf_busy_d     = perf_busy_q;
        if (grant_any && (perf_issue_q != '1)) begin
            perf_issue_d = perf_issue_q + 32'd1;
        end
        if (i_enable && multi_req && (perf_conflict_q != '1)) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
        if (busy && (perf_busy_q != '1)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_issue_q    <= '0;
            perf_conflict_q <= '0;
            perf_busy_q     <= '0;
        end else begin
            perf_issue_q    <= perf_issue_d;
            perf_conflict_q <= perf_conflict_d;
            perf_busy_q     <= perf_busy_d;
        end
    end

    assign o_perf_issue_cnt    = perf_issue_q;
    assign o_perf_conflict_cnt = perf_conflict_q;
    assign o_perf_busy_cnt     = perf_busy_q;
`else
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_req_ready  = req_ready;
    assign bus.o_unit_x     = unit_x_q;
    assign bus.o_unit_y     = unit_y_q;
    assign bus.o_unit_z     = unit_z_q;
    assign bus.o_unit_valid = unit_valid_q;
    assign bus.o_res_x      = res_x_q;
    assign bus.o_res_y      = res_y_q;
    assign bus.o_res_z      = res_z_q;
    assign bus.o_res_tag    = res_tag_q;
    assign bus.o_res_valid  = res_valid_q;
    assign o_busy           = busy;

endmodule

// File: tb/tb_vec_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vec_unit_arbiter
//   Directed scenarios followed by a randomized phase. The vector unit is
//   modelled as a LATENCY-deep delay line. Expected values come from a
//   behavioural model: round-robin pick from the pointer, a queue of pending
//   results with their due edge, and simple counters.
// ---------------------------------------------------------------------------
module tb_vec_unit_arbiter;

    localparam int N  = 4;
    localparam int L  = 9;
    localparam int TW = 2;

    logic clk;
    logic rst_n;
    logic enable;
    logic busy;
`ifdef VEC_UNIT_ARB_PERF_EN
    logic [31:0] perf_issue;
    logic [31:0] perf_conflict;
    logic [31:0] perf_busy;
`endif

    vec_unit_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

    vec_unit_arbiter #(.NUM_REQ(N), .LATENCY(L), .TAG_W(TW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (enable),
        .bus      (bus),
        .o_busy   (busy)
`ifdef VEC_UNIT_ARB_PERF_EN
        ,
        .o_perf_issue_cnt    (perf_issue),
        .o_perf_conflict_cnt (perf_conflict),
        .o_perf_busy_cnt     (perf_busy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Vector unit stand-in: pure delay line
    logic [26:0] dl_x [L];
    logic [26:0] dl_y [L];
    logic [26:0] dl_z [L];

    always @(posedge clk) begin
        dl_x[0] <= bus.o_unit_x;
        dl_y[0] <= bus.o_unit_y;
        dl_z[0] <= bus.o_unit_z;
        for (int i = 1; i < L; i++) begin
            dl_x[i] <= dl_x[i-1];
            dl_y[i] <= dl_y[i-1];
            dl_z[i] <= dl_z[i-1];
        end
    end

    assign bus.i_unit_x = dl_x[L-1];
    assign bus.i_unit_y = dl_y[L-1];
    assign bus.i_unit_z = dl_z[L-1];

    // Bench state
    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] vld;
    logic [26:0] op_x [N];
    logic [26:0] op_y [N];
    logic [26:0] op_z [N];
    bit          keep_on_grant;
    bit          armed;
    int          res_seen;
    logic [N-1:0] last_rdy;

    // Reference model
    typedef struct {
        int          due;
        int          k;
        logic [26:0] x;
        logic [26:0] y;
        logic [26:0] z;
    } res_t;

    res_t        m_q[$];
    int          m_ptr;
    int          m_edge;
    logic        m_uv;
    logic [26:0] m_ux, m_uy, m_uz;
    logic [26:0] m_rx, m_ry, m_rz;
    logic [N-1:0] m_rv;
    int          m_rtag;
    logic        m_busy;
    logic [31:0] m_pi, m_pc, m_pb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic en, input int p);
        logic [N-1:0] r;
        r = '0;
        if (en) begin
            for (int d = 0; d < N; d++) begin
                if (v[(p + d) % N]) begin
                    r[(p + d) % N] = 1'b1;
                    return r;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic new_ops(input int k);
        op_x[k] = 27'($urandom);
        op_y[k] = 27'($urandom);
        op_z[k] = 27'($urandom);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_q.delete();
        m_uv   = 1'b0;
        m_ux   = '0; m_uy = '0; m_uz = '0;
        m_rx   = '0; m_ry = '0; m_rz = '0;
        m_rv   = '0;
        m_rtag = 0;
        m_busy = 1'b0;
        m_pi   = '0; m_pc = '0; m_pb = '0;
    endtask

    // One clock: drive inputs, check grant, advance model, check outputs.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int           gk;
        logic         was_busy;
        logic         conflict;
        res_t         r;

        for (int k = 0; k < N; k++) begin
            bus.i_req_x[k*27 +: 27] = op_x[k];
            bus.i_req_y[k*27 +: 27] = op_y[k];
            bus.i_req_z[k*27 +: 27] = op_z[k];
        end
        bus.i_req_valid = vld;
        #1;
        exp_rdy  = model_ready(vld, enable, m_ptr);
        last_rdy = bus.o_req_ready;
        if (armed) check("ready", bus.o_req_ready, 32'(exp_rdy));
        gk = -1;
        for (int k = 0; k < N; k++) if (exp_rdy[k]) gk = k;
        was_busy = m_busy;
        conflict = enable && ($countones(vld) > 1);

        @(posedge clk);
        m_edge++;
        if (!rst_n) begin
            model_reset();
            armed = 1'b1;
        end else begin
            if (was_busy) m_pb = sat_inc(m_pb);
            if (conflict) m_pc = sat_inc(m_pc);
            m_uv = 1'b0;
            m_rv = '0;
            if (gk >= 0) begin
                m_pi  = sat_inc(m_pi);
                r.due = m_edge + L + 1;
                r.k   = gk;
                r.x   = op_x[gk];
                r.y   = op_y[gk];
                r.z   = op_z[gk];
                m_q.push_back(r);
                m_uv  = 1'b1;
                m_ux  = r.x; m_uy = r.y; m_uz = r.z;
                m_ptr = (gk + 1) % N;
            end
            if (m_q.size() > 0 && m_q[0].due == m_edge) begin
                r = m_q.pop_front();
                m_rv[r.k] = 1'b1;
                m_rx   = r.x; m_ry = r.y; m_rz = r.z;
                m_rtag = r.k;
            end
            m_busy = (m_q.size() != 0);
            if (gk >= 0) begin
                new_ops(gk);
                if (!keep_on_grant) vld[gk] = 1'b0;
            end
        end

        #1;
        if (bus.o_res_valid != '0) res_seen++;
        if (armed) begin
            check("unit_valid", bus.o_unit_valid, 32'(m_uv));
            check("unit_x", bus.o_unit_x, 32'(m_ux));
            check("unit_y", bus.o_unit_y, 32'(m_uy));
            check("unit_z", bus.o_unit_z, 32'(m_uz));
            check("res_valid", bus.o_res_valid, 32'(m_rv));
            check("res_x", bus.o_res_x, 32'(m_rx));
            check("res_y", bus.o_res_y, 32'(m_ry));
            check("res_z", bus.o_res_z, 32'(m_rz));
            if (m_rv != '0) check("res_tag", bus.o_res_tag, 32'(m_rtag));
            check("busy", busy, 32'(m_busy));
`ifdef VEC_UNIT_ARB_PERF_EN
            check("perf_issue", perf_issue, m_pi);
            check("perf_conflict", perf_conflict, m_pc);
            check("perf_busy", perf_busy, m_pb);
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int res0;

        rst_n         = 1'b0;
        enable        = 1'b1;
        vld           = '0;
        keep_on_grant = 1'b0;
        armed         = 1'b0;
        res_seen      = 0;
        m_edge        = 0;
        model_reset();
        for (int k = 0; k < N; k++) new_ops(k);

        // Reset state
        cycle();
        cycle();
        rst_n = 1'b1;
        check("rst_busy", busy, 32'd0);
        check("rst_unit_valid", bus.o_unit_valid, 32'd0);
        check("rst_res_valid", bus.o_res_valid, 32'd0);
        check("rst_res_x", bus.o_res_x, 32'd0);

        // Single op from requester 0
        op_x[0] = 27'h1FC0000;
        op_y[0] = 27'h2000000;
        op_z[0] = 27'h0;
        vld     = 4'b0001;
        cycle();
        check("single_ready", last_rdy, 32'h1);
        check("single_issue", bus.o_unit_valid, 32'd1);
        check("single_unit_x", bus.o_unit_x, 32'h1FC0000);
        repeat (9) cycle();
        check("single_not_early", bus.o_res_valid, 32'd0);
        cycle();
        check("single_res_valid", bus.o_res_valid, 32'h1);
        check("single_res_x", bus.o_res_x, 32'h1FC0000);
        check("single_res_y", bus.o_res_y, 32'h2000000);
        check("single_res_tag", bus.o_res_tag, 32'd0);
        repeat (3) cycle();

        // Full contention, starting from pointer 0
        do_reset();
        vld           = 4'b1111;
        keep_on_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check($sformatf("cont_grant%0d", i), last_rdy, 32'(1 << (i % 4)));
        end
`ifdef VEC_UNIT_ARB_PERF_EN
        check("perf_cont_issue", perf_issue, 32'd8);
        check("perf_cont_conflict", perf_conflict, 32'd8);
`endif
        vld           = '0;
        keep_on_grant = 1'b0;
        res0          = res_seen;
        repeat (12) cycle();
        check("cont_results", res_seen - res0, 32'd8);

        // Pointer wrap and skip
        vld = 4'b0100;
        cycle();
        check("wrap_g2", last_rdy, 32'b0100);
        vld = 4'b1010;
        cycle();
        check("skip_g3", last_rdy, 32'b1000);
        cycle();
        check("skip_g1", last_rdy, 32'b0010);
        repeat (12) cycle();

        // Enable pause after three issued ops (grants 2,3,0, pointer -> 1)
        vld           = 4'b1111;
        keep_on_grant = 1'b1;
        repeat (3) cycle();
        enable = 1'b0;
        cycle();
        check("pause_ready", last_rdy, 32'd0);
        res0 = res_seen;
        repeat (13) cycle();
        check("pause_drained", res_seen - res0, 32'd3);
        check("pause_idle", busy, 32'd0);
        enable = 1'b1;
        cycle();
        check("resume_g1", last_rdy, 32'b0010);
        vld           = '0;
        keep_on_grant = 1'b0;
        repeat (12) cycle();

        // Mid-flight reset
        vld           = 4'b1111;
        keep_on_grant = 1'b1;
        repeat (3) cycle();
        do_reset();
        vld           = '0;
        keep_on_grant = 1'b0;
        check("mrst_busy", busy, 32'd0);
        check("mrst_unit_valid", bus.o_unit_valid, 32'd0);
        check("mrst_unit_x", bus.o_unit_x, 32'd0);
        check("mrst_res_valid", bus.o_res_valid, 32'd0);
        res0 = res_seen;
        repeat (14) cycle();
        check("mrst_no_results", res_seen - res0, 32'd0);
        vld = 4'b1111;
        cycle();
        check("mrst_first_g0", last_rdy, 32'b0001);
        vld = '0;
        repeat (12) cycle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst_n         = ($urandom_range(0, 99) >= 2);
            enable        = ($urandom_range(0, 9) != 0);
            keep_on_grant = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) begin
                if (!vld[k]) new_ops(k);
                vld[k] = ($urandom_range(0, 99) < 55);
            end
            cycle();
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        vld    = '0;
        repeat (14) cycle();
        check("final_idle", busy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
